// File: rtl/led_pwm_pkg.sv
// Shared register map, channel mode encoding and response codes for led_pwm_axil.
package led_pwm_pkg;

    localparam int unsigned PRESC_W = 16;
    localparam int unsigned BLINK_W = 16;
    localparam int unsigned PWM_W   = 8;
    localparam int unsigned DUTY_W  = 8;

    // Byte offsets of the register map.
    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_BLINK    = 8'h08;
    localparam logic [7:0] OFF_CH_BASE  = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    // Per-channel configuration; the packed layout matches the CH_i register bits 9:0.
    typedef struct packed {
        mode_t               mode;
        logic [DUTY_W-1:0]   duty;
    } ch_cfg_t;

    // Byte offset of channel register i.
    function automatic logic [7:0] ch_offset(input int unsigned i);
        return OFF_CH_BASE + 8'(i * 4);
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: duty compare against the shared PWM counter and mode select.
module led_pwm_channel
    import led_pwm_pkg::*;
(
    input  ch_cfg_t          cfg,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             blink_phase,
    output logic             led_c
);

    logic below_duty;

    assign below_duty = (pwm_cnt < cfg.duty);

    // Mode mux; the result is registered by the top level.
    always_comb begin
        led_c = 1'b0;
        case (cfg.mode)
            MODE_OFF:   led_c = 1'b0;
            MODE_ON:    led_c = 1'b1;
            MODE_PWM:   led_c = below_duty;
            MODE_BLINK: led_c = below_duty & blink_phase;
            default:    led_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pwm_axil.sv
// AXI4-Lite controlled multi-channel LED PWM/blink driver.
module led_pwm_axil
    import led_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_CH-1:0]                 led
);

    localparam int unsigned WIDX_W = C_S_AXI_ADDR_WIDTH - 2;

    logic                          ctrl_en;
    logic [PRESC_W-1:0]            prescale;
    logic [BLINK_W-1:0]            blink;
    ch_cfg_t                       ch_cfg [NUM_CH];

    logic [PRESC_W-1:0]            presc_cnt;
    logic [PWM_W-1:0]              pwm_cnt;
    logic [BLINK_W-1:0]            blink_cnt;
    logic                          blink_phase;

    logic [WIDX_W-1:0]             aw_idx;
    logic [WIDX_W-1:0]             ar_idx;
    logic                          wr_fire_c;
    logic                          rd_fire_c;
    logic                          tick_c;
    logic                          wr_ok_c;
    logic                          wr_ctrl_c;
    logic                          wr_presc_c;
    logic                          wr_blink_c;
    logic [NUM_CH-1:0]             wr_ch_c;
    logic                          rd_ok_c;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_CH-1:0]             led_c;

    // Address bits that never select a register, plus protection info.
    logic unused_c;
    assign unused_c = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                        s00_axi_wdata[C_S_AXI_DATA_WIDTH-1:16], s00_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:2]};

    assign aw_idx    = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx    = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire_c = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_fire_c = s00_axi_arready & s00_axi_arvalid;
    assign tick_c    = ctrl_en && (presc_cnt == prescale);

    // Write address decode.
    always_comb begin
        wr_ch_c    = '0;
        wr_ctrl_c  = (aw_idx == WIDX_W'(OFF_CTRL >> 2));
        wr_presc_c = (aw_idx == WIDX_W'(OFF_PRESCALE >> 2));
        wr_blink_c = (aw_idx == WIDX_W'(OFF_BLINK >> 2));
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_ch_c[i] = (aw_idx == WIDX_W'(ch_offset(i) >> 2));
        end
        wr_ok_c = wr_ctrl_c | wr_presc_c | wr_blink_c | (|wr_ch_c);
    end

    // Read data mux; unmapped offsets return zero with an error flag.
    always_comb begin
        rd_data_c = '0;
        rd_ok_c   = 1'b0;
        if (ar_idx == WIDX_W'(OFF_CTRL >> 2)) begin
            rd_data_c[0] = ctrl_en;
            rd_ok_c      = 1'b1;
        end else if (ar_idx == WIDX_W'(OFF_PRESCALE >> 2)) begin
            rd_data_c[PRESC_W-1:0] = prescale;
            rd_ok_c                = 1'b1;
        end else if (ar_idx == WIDX_W'(OFF_BLINK >> 2)) begin
            rd_data_c[BLINK_W-1:0] = blink;
            rd_ok_c                = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ar_idx == WIDX_W'(ch_offset(i) >> 2)) begin
                rd_data_c[$bits(ch_cfg_t)-1:0] = ch_cfg[i];
                rd_ok_c                        = 1'b1;
            end
        end
    end

    // Write handshake: accept only with both channels valid and no response pending.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
        end else begin
            s00_axi_awready <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_awready & ~s00_axi_bvalid;
            s00_axi_wready  <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_awready & ~s00_axi_bvalid;
            if (wr_fire_c) begin
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
        end
    end

    // Register file with per-byte strobes; unmapped writes select nothing.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            ctrl_en  <= 1'b0;
            prescale <= '0;
            blink    <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ch_cfg[i] <= '0;
            end
        end else if (wr_fire_c) begin
            if (wr_ctrl_c && s00_axi_wstrb[0]) ctrl_en <= s00_axi_wdata[0];
            if (wr_presc_c) begin
                if (s00_axi_wstrb[0]) prescale[7:0]  <= s00_axi_wdata[7:0];
                if (s00_axi_wstrb[1]) prescale[15:8] <= s00_axi_wdata[15:8];
            end
            if (wr_blink_c) begin
                if (s00_axi_wstrb[0]) blink[7:0]  <= s00_axi_wdata[7:0];
                if (s00_axi_wstrb[1]) blink[15:8] <= s00_axi_wdata[15:8];
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_ch_c[i]) begin
                    if (s00_axi_wstrb[0]) ch_cfg[i].duty <= s00_axi_wdata[7:0];
                    if (s00_axi_wstrb[1]) ch_cfg[i].mode <= mode_t'(s00_axi_wdata[9:8]);
                end
            end
        end
    end

    // Read handshake; rdata is captured at acceptance so a same-cycle write returns the old value.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            s00_axi_arready <= s00_axi_arvalid & ~s00_axi_arready & ~s00_axi_rvalid;
            if (rd_fire_c) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_data_c;
                s00_axi_rresp  <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    // Prescaler, shared PWM counter and blink phase; all parked at zero while disabled.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset || !ctrl_en) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (wr_fire_c && wr_presc_c) begin
                presc_cnt <= '0;
            end else if (tick_c) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end

            if (tick_c) pwm_cnt <= pwm_cnt + PWM_W'(1);

            if (wr_fire_c && wr_blink_c) begin
                blink_cnt <= '0;
            end else if (tick_c) begin
                if (blink_cnt == blink) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        led_pwm_channel u_ch (
            .cfg         (ch_cfg[g]),
            .pwm_cnt     (pwm_cnt),
            .blink_phase (blink_phase),
            .led_c       (led_c[g])
        );
    end

    // Registered LED drive, forced off while disabled.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset || !ctrl_en) begin
            led <= '0;
        end else begin
            led <= led_c;
        end
    end

endmodule

// File: tb/tb_led_pwm_axil.sv
// Self-checking bench for led_pwm_axil: register map, handshakes, LED timing vs. an arithmetic model.
module tb_led_pwm_axil;

    localparam int NUM_CH = 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        areset;
    logic [5:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [NUM_CH-1:0] led;

    led_pwm_axil #(.NUM_CH(NUM_CH), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .led             (led)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int passes    = 0;
    int cyc       = 0;
    int last_fire = 0;
    logic [31:0] shadow [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    // Writable bits of each register word; zero means the word is unmapped.
    function automatic logic [31:0] word_mask(input int w);
        if (w == 0) return 32'h0000_0001;
        if (w == 1 || w == 2) return 32'h0000_FFFF;
        if (w >= 4 && w < 4 + NUM_CH) return 32'h0000_03FF;
        return 32'h0;
    endfunction

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        last_fire = cyc;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        while (!bvalid && n < 40) begin @(negedge clk); n++; end
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
        check("wr_done_in_budget", 64'(n < 40), 64'(1));
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        while (!rvalid && n < 40) begin @(negedge clk); n++; end
        d = rdata; r = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rd_done_in_budget", 64'(n < 40), 64'(1));
    endtask

    // Write through the bus, check the response and update the shadow register model.
    task automatic reg_write(input int w, input logic [31:0] d, input logic [3:0] s);
        logic [1:0]  resp;
        logic [31:0] m;
        logic [31:0] bm;
        axi_write(6'(w * 4), d, s, resp);
        m = word_mask(w);
        check($sformatf("bresp_word%0d", w), 64'(resp), 64'((m != 0) ? OKAY : SLVERR));
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & m;
        shadow[w] = (shadow[w] & ~bm) | (d & bm);
    endtask

    task automatic sweep(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        logic [33:0] expv;
        for (int w = 0; w < 16; w++) begin
            axi_read(6'(w * 4), d, r);
            expv = (word_mask(w) != 0) ? {OKAY, shadow[w]} : {SLVERR, 32'h0};
            check($sformatf("%s_word%0d", tag, w), 64'({r, d}), 64'(expv));
        end
    endtask

    // LED value after c enabled cycles of counting, from the period arithmetic.
    function automatic logic exp_led(input int ch, input int c);
        int k, pwm, ph, duty, mode;
        k    = c / (int'(shadow[1][15:0]) + 1);
        pwm  = k % 256;
        ph   = (k / (int'(shadow[2][15:0]) + 1)) % 2;
        duty = int'(shadow[4 + ch][7:0]);
        mode = int'(shadow[4 + ch][9:8]);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return pwm < duty;
            default: return (pwm < duty) && (ph == 1);
        endcase
    endfunction

    int mism, first_j, hi0_a, hi1_a, hi1_b;

    // Compare led every cycle; enable took effect at the edge counted as e0.
    task automatic run_leds(input int ncyc, input int e0);
        int j;
        logic [NUM_CH-1:0] expv;
        mism = 0; first_j = -1; hi0_a = 0; hi1_a = 0; hi1_b = 0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            j = cyc - e0;
            if (j >= 1) begin
                for (int ch = 0; ch < NUM_CH; ch++) expv[ch] = exp_led(ch, j - 1);
                if (led !== expv) begin
                    if (mism == 0) first_j = j;
                    mism++;
                end
                if (j >= 257 && j <= 512) begin hi0_a += int'(led[0]); hi1_a += int'(led[1]); end
                if (j >= 513 && j <= 768) hi1_b += int'(led[1]);
            end
        end
    endtask

    initial begin
        logic [31:0] d1;
        logic [1:0]  r1, r2;
        int          n;

        areset = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int w = 0; w < 16; w++) shadow[w] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, led}), 64'(0));
        areset = 1'b0;

        // CTRL write/readback.
        reg_write(0, 32'h0000_0001, 4'hF);
        axi_read(6'h00, d1, r1);
        check("ctrl_readback", 64'({r1, d1}), 64'({OKAY, 32'h1}));
        reg_write(0, 32'h0, 4'hF);

        // Randomized register traffic, including unmapped words and partial strobes.
        for (int i = 0; i < 24; i++) begin
            reg_write(int'($urandom_range(15, 1)), $urandom, 4'($urandom_range(15, 0)));
        end
        reg_write(11, 32'hFFFF_FFFF, 4'hF);
        sweep("rand_regs");

        // Partial strobe leaves the MODE byte untouched.
        reg_write(6, 32'h0, 4'hF);
        reg_write(6, 32'h0000_0201, 4'h1);
        axi_read(6'h18, d1, r1);
        check("ch2_strobe_byte0", 64'({r1, d1}), 64'({OKAY, 32'h1}));

        // Simultaneous write and read of PRESCALE returns the old value.
        reg_write(1, 32'h0000_0005, 4'hF);
        fork
            axi_write(6'h04, 32'h0000_0009, 4'hF, r2);
            axi_read(6'h04, d1, r1);
        join
        shadow[1] = 32'h9;
        check("same_reg_rw_old", 64'({r1, d1}), 64'({OKAY, 32'h5}));
        check("same_reg_rw_bresp", 64'(r2), 64'(OKAY));
        axi_read(6'h04, d1, r1);
        check("same_reg_rw_new", 64'({r1, d1}), 64'({OKAY, 32'h9}));

        // PWM 64/256 on CH0 and 256-cycle blink windows on CH1.
        reg_write(0, 32'h0, 4'hF);
        reg_write(1, 32'h0, 4'hF);
        reg_write(2, 32'd255, 4'hF);
        reg_write(4, 32'h0000_0240, 4'hF);
        reg_write(5, 32'h0000_03FF, 4'hF);
        reg_write(6, $urandom, 4'hF);
        reg_write(7, $urandom, 4'hF);
        reg_write(0, 32'h1, 4'hF);
        run_leds(800, last_fire);
        check($sformatf("led_model_fixed first_j=%0d", first_j), 64'(mism), 64'(0));
        check("ch0_pwm64_highs", 64'(hi0_a), 64'(64));
        check("ch1_blink_on_window", 64'(hi1_a), 64'(255));
        check("ch1_blink_off_window", 64'(hi1_b), 64'(0));

        // Random periods and channel configurations.
        for (int s = 0; s < 3; s++) begin
            reg_write(0, 32'h0, 4'hF);
            repeat (2) @(negedge clk);
            check($sformatf("led_off_disabled_%0d", s), 64'(led), 64'(0));
            reg_write(1, 32'($urandom_range(3, 0)), 4'hF);
            reg_write(2, 32'($urandom_range(7, 0)), 4'hF);
            for (int ch = 0; ch < NUM_CH; ch++) reg_write(4 + ch, $urandom, 4'hF);
            reg_write(0, 32'h1, 4'hF);
            run_leds(1200, last_fire);
            check($sformatf("led_model_rand%0d first_j=%0d", s, first_j), 64'(mism), 64'(0));
        end

        // Reset while a write response is held pending.
        reg_write(4, 32'h0000_0100, 4'hF);
        repeat (3) @(negedge clk);
        check("led0_on_before_reset", 64'(led[0]), 64'(1));
        @(negedge clk);
        awaddr = 6'h08; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 40) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("bvalid_held_pending", 64'({bvalid, bresp}), 64'({1'b1, OKAY}));
        areset = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        repeat (3) @(negedge clk);
        check("bvalid_dropped_by_reset", 64'(bvalid), 64'(0));
        check("led_after_reset", 64'(led), 64'(0));
        for (int w = 0; w < 16; w++) shadow[w] = '0;
        sweep("post_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
